// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU load/store path vs. debug/loader port, round-robin on ties.
// Optional macro DMEM_ARB_STARVE_LIMIT_EN caps locked debug bursts at MAX_DBG_RUN when the CPU waits.
//
//   state   | meaning
//   IDLE    | no grant; arbitrate pending requests
//   GNT_CPU | CPU access performed and acknowledged this cycle
//   GNT_DBG | debug access performed this cycle; held while dbg_lock
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          MEMORY_DEPTH = 1024,
    parameter int          ADDR_W       = 10,
    parameter int          MAX_DBG_RUN  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [31:0]       i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_stall,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic              i_dbg_lock,
    input  logic [31:0]       i_dbg_addr,
    input  logic [31:0]       i_dbg_wdata,
    output logic [31:0]       o_dbg_rdata,
    output logic              o_dbg_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_addr_fault
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DBG} state_t;

    localparam logic [31:0] LIMIT = 32'(4 * MEMORY_DEPTH);

    state_t            r_state, w_state_next;
    logic              r_last_dbg;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata, r_cpu_rdata, r_dbg_rdata;

    logic              w_cpu_gnt, w_dbg_gnt, w_gnt, w_we, w_fault, w_starve;
    logic [31:0]       w_addr, w_wdata, w_off, w_rdata;
    logic [ADDR_W-1:0] w_idx;

    // Reset mid-grant suppresses the access in that same cycle.
    assign w_cpu_gnt = (r_state == GNT_CPU) && !i_reset;
    assign w_dbg_gnt = (r_state == GNT_DBG) && !i_reset;
    assign w_gnt     = w_cpu_gnt | w_dbg_gnt;

    assign w_addr  = w_dbg_gnt ? i_dbg_addr  : i_cpu_addr;
    assign w_we    = w_dbg_gnt ? i_dbg_we    : i_cpu_we;
    assign w_wdata = w_dbg_gnt ? i_dbg_wdata : i_cpu_wdata;

    // Offset wraps, so addresses below the base land far above LIMIT.
    assign w_off   = w_addr - BASE_ADDR;
    assign w_fault = (w_off[1:0] != 2'b00) || (w_off >= LIMIT);
    assign w_idx   = w_off[ADDR_W+1:2];
    assign w_rdata = w_fault ? 32'h0 : i_mem_rdata;

    assign o_mem_addr   = i_reset ? '0    : (w_gnt ? w_idx : r_mem_addr);
    assign o_mem_wdata  = i_reset ? 32'h0 : (w_gnt ? w_wdata : r_mem_wdata);
    assign o_mem_we     = w_gnt & w_we & ~w_fault;
    assign o_mem_re     = w_gnt & ~w_we & ~w_fault;
    assign o_cpu_ack    = w_cpu_gnt;
    assign o_dbg_ack    = w_dbg_gnt;
    assign o_addr_fault = w_gnt & w_fault;
    assign o_cpu_rdata  = i_reset ? 32'h0 : (w_cpu_gnt ? w_rdata : r_cpu_rdata);
    assign o_dbg_rdata  = i_reset ? 32'h0 : (w_dbg_gnt ? w_rdata : r_dbg_rdata);
    assign o_cpu_stall  = i_cpu_req & ~w_cpu_gnt & ~i_reset;

`ifdef DMEM_ARB_STARVE_LIMIT_EN
    localparam int RUN_W = ($clog2(MAX_DBG_RUN + 1) > 4) ? $clog2(MAX_DBG_RUN + 1) : 4;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_DBG_RUN - 1);

    // r_run counts debug grants already completed in the current burst.
    logic [RUN_W-1:0] r_run;

    assign w_starve = i_cpu_req && (r_run >= RUN_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run <= '0;
        end else if ((r_state == GNT_DBG) && (w_state_next == GNT_DBG)) begin
            if (r_run < RUN_LAST) begin
                r_run <= r_run + 1'b1;
            end
        end else begin
            r_run <= '0;
        end
    end
`else
    logic [31:0] w_unused_max_run;
    assign w_unused_max_run = 32'(MAX_DBG_RUN);
    assign w_starve         = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_cpu_req && i_dbg_req) begin
                    w_state_next = r_last_dbg ? GNT_CPU : GNT_DBG;
                end else if (i_cpu_req) begin
                    w_state_next = GNT_CPU;
                end else if (i_dbg_req) begin
                    w_state_next = GNT_DBG;
                end
            end
            GNT_CPU: w_state_next = IDLE;
            GNT_DBG: begin
                if (!(i_dbg_lock && i_dbg_req) || w_starve) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_last_dbg  <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_cpu_rdata <= 32'h0;
            r_dbg_rdata <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_gnt) begin
                r_last_dbg  <= w_dbg_gnt;
                r_mem_addr  <= w_idx;
                r_mem_wdata <= w_wdata;
            end
            if (w_cpu_gnt) begin
                r_cpu_rdata <= w_rdata;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= w_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle sequences and
// randomized traffic against a transaction-level reference model with a shadow memory.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam int          DEPTH  = 1024;
    localparam int          MAXRUN = 8;
`ifdef DMEM_ARB_STARVE_LIMIT_EN
    localparam int EXP_RUN = MAXRUN;
    localparam bit STARVE  = 1'b1;
`else
    localparam int EXP_RUN = 12;
    localparam bit STARVE  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, dbg_ack, mem_we, mem_re, addr_fault;
    logic [9:0]  mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .BASE_ADDR(BASE), .MEMORY_DEPTH(DEPTH), .ADDR_W(10), .MAX_DBG_RUN(MAXRUN)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack), .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_lock(dbg_lock), .i_dbg_addr(dbg_addr),
        .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_re(mem_re),
        .i_mem_rdata(mem_rdata), .o_addr_fault(addr_fault)
    );

    // DataMemory model: combinational read, write on clock edge.
    logic [31:0] dmem [0:DEPTH-1];
    logic [31:0] shadow [0:DEPTH-1];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    assign mem_rdata = dmem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [5:0] ctl();
        return {cpu_ack, dbg_ack, mem_we, mem_re, addr_fault, cpu_stall};
    endfunction

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_slot();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = BASE; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = BASE; dbg_wdata = 0;
    endtask

    // Returns one tick after reset release, with the arbiter in IDLE and memory reinitialised.
    task automatic do_reset();
        reset = 1; clear_inputs(); mem_init = 1;
        @(posedge clk); #1 mem_init = 0;
        @(posedge clk); #1 reset = 0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    endtask

    typedef struct {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  idx;
        logic        fault;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return $urandom;
        if (r == 1) return BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
        if (r == 2) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
        if (r == 3) return BASE + 32'(4 * (DEPTH - 1));
        return BASE + 32'(4 * $urandom_range(0, 31));
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] pat [10];
        logic [31:0] rd;
        int dbg_cnt, cpu_first, run, run_last, before_cpu;
        bit run_open, dbg_active, p_cpu, p_dbg;
        int m_owner, m_run, nxt;
        bit m_last_dbg, cpu_pend, dbg_pend, gc, gd, g, w, f, starve;
        logic [9:0] m_idx, e_idx;
        logic [31:0] m_wd, a, wd, off, e_rd;

        // ---------------- reset values ----------------
        reset = 1; clear_inputs();
        cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
        cpu_wdata = 32'h1234_5678; dbg_wdata = 32'h8765_4321;
        repeat (2) @(posedge clk);
        sample_slot();
        check("rst_ctl",   64'(ctl()), 64'h0);
        check("rst_addr",  64'(mem_addr), 64'h0);
        check("rst_wdata", 64'(mem_wdata), 64'h0);
        check("rst_crd",   64'(cpu_rdata), 64'h0);
        check("rst_drd",   64'(dbg_rdata), 64'h0);

        // ---------------- directed vector table ----------------
        tbl[0] = '{1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 10'd2,    1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         10'd2,    1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b0, 32'h1000_FFFC, 32'h0,         10'd0,    1'b1, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h1001_0002, 32'h0,         10'd0,    1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h1001_1000, 32'h1,         10'd0,    1'b1, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 32'h1001_0FFC, 32'h1234_5678, 10'd1023, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h1001_0FFC, 32'h0,         10'd1023, 1'b0, 32'h1234_5678};
        tbl[7] = '{1'b1, 1'b1, 32'h1001_0010, 32'h0BAD_F00D, 10'd4,    1'b0, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h1001_0010, 32'h0,         10'd4,    1'b0, 32'h0BAD_F00D};
        tbl[9] = '{1'b1, 1'b0, 32'h1001_0006, 32'h0,         10'd0,    1'b1, 32'h0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].dbg) begin
                dbg_req = 1; dbg_we = tbl[i].we; dbg_addr = tbl[i].addr; dbg_wdata = tbl[i].wdata;
            end else begin
                cpu_req = 1; cpu_we = tbl[i].we; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
            end
            sample_slot();
            check($sformatf("v%0d_wait", i), 64'({cpu_ack, dbg_ack, cpu_stall}), 64'({2'b00, !tbl[i].dbg}));
            drive_slot();
            sample_slot();
            check($sformatf("v%0d_ctl", i), 64'(ctl()),
                  64'({!tbl[i].dbg, tbl[i].dbg, tbl[i].we & !tbl[i].fault,
                       !tbl[i].we & !tbl[i].fault, tbl[i].fault, 1'b0}));
            if (!tbl[i].fault) check($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(tbl[i].idx));
            if (!tbl[i].we) begin
                rd = tbl[i].dbg ? dbg_rdata : cpu_rdata;
                check($sformatf("v%0d_rdata", i), 64'(rd), 64'(tbl[i].rdata));
            end
            drive_slot();
            clear_inputs();
            sample_slot();
            check($sformatf("v%0d_after", i), 64'(ctl()), 64'h0);
            if (!tbl[i].fault) check($sformatf("v%0d_hold", i), 64'(mem_addr), 64'(tbl[i].idx));
            drive_slot();
        end

        // ---------------- round-robin with both requesting ----------------
        pat = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        do_reset();
        cpu_req = 1; cpu_addr = BASE + 32'h20; dbg_req = 1; dbg_addr = BASE + 32'h24;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) drive_slot();
            sample_slot();
            check($sformatf("rr_c%0d", c), 64'({cpu_ack, dbg_ack}), 64'(pat[c]));
        end

        // ---------------- locked debug burst vs waiting CPU ----------------
        do_reset();
        dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = BASE; dbg_active = 1;
        dbg_cnt = 0; cpu_first = -1; run = 0; run_last = -1; run_open = 1; before_cpu = 0;
        p_cpu = 0; p_dbg = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                drive_slot();
                if (c == 1) begin cpu_req = 1; cpu_we = 0; cpu_addr = BASE + 32'h40; end
                if (p_cpu) cpu_req = 0;
                if (dbg_active && p_dbg) dbg_addr = dbg_addr + 32'd4;
                if (dbg_active && dbg_ack && (dbg_cnt + 1 == 12)) begin
                    dbg_req = 0; dbg_lock = 0; dbg_active = 0;
                end
            end
            sample_slot();
            p_cpu = cpu_ack; p_dbg = dbg_ack;
            if (dbg_ack) begin
                dbg_cnt++;
                if (cpu_first < 0) before_cpu++;
                if (run_open) begin run++; run_last = c; end
            end else if (run > 0) begin
                run_open = 0;
            end
            if (cpu_ack && cpu_first < 0) cpu_first = c;
        end
        check("lock_cpu_acked", 64'(cpu_first >= 0), 64'd1);
        check("lock_run",       64'(run), 64'(EXP_RUN));
        check("lock_before",    64'(before_cpu), 64'(EXP_RUN));
        check("lock_gap",       64'(cpu_first - run_last), 64'd2);
        check("lock_total",     64'(dbg_cnt), 64'd12);

        // ---------------- reset during a debug write grant ----------------
        do_reset();
        dbg_req = 1; dbg_we = 1; dbg_addr = BASE + 32'h14; dbg_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1 reset = 1;
        sample_slot();
        check("rstmid_ctl", 64'({ctl(), dbg_ack}), 64'h0);
        drive_slot();
        reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = BASE + 32'h20;
        sample_slot();
        check("rstmid_nowrite", 64'(dmem[5]), 64'(init_val(5)));
        check("rstmid_idle",    64'(ctl()), 64'b000001);
        drive_slot();
        sample_slot();
        check("rstmid_cpuwins", 64'({cpu_ack, dbg_ack}), 64'b10);

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        m_owner = 0; m_run = 0; m_last_dbg = 1; m_idx = '0; m_wd = '0;
        cpu_pend = 0; dbg_pend = 0; p_cpu = 0; p_dbg = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) drive_slot();
            if (cpu_pend && p_cpu) cpu_pend = 0;
            if (!cpu_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_pend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = rand_addr(); cpu_wdata = $urandom;
                end else cpu_req = 0;
            end
            if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
            if (dbg_pend && p_dbg) dbg_pend = 0;
            if (!dbg_pend) begin
                if ($urandom_range(0, 3) < (dbg_lock ? 3 : 1)) begin
                    dbg_pend = 1; dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
                    dbg_addr = rand_addr(); dbg_wdata = $urandom;
                end else dbg_req = 0;
            end

            sample_slot();
            gc = (m_owner == 1); gd = (m_owner == 2); g = gc | gd;
            a  = gd ? dbg_addr : cpu_addr;
            w  = gd ? dbg_we : cpu_we;
            wd = gd ? dbg_wdata : cpu_wdata;
            off = a - BASE;
            f = ((off % 4) != 0) || (off >= 32'(4 * DEPTH));
            e_idx = g ? 10'(off / 4) : m_idx;
            check("rnd_ctl",   64'(ctl()), 64'({gc, gd, g & w & !f, g & !w & !f, g & f, cpu_req & !gc}));
            check("rnd_addr",  64'(mem_addr), 64'(e_idx));
            check("rnd_wdata", 64'(mem_wdata), 64'(g ? wd : m_wd));
            if (g && !w) begin
                e_rd = f ? 32'h0 : shadow[int'(off / 4)];
                check(gd ? "rnd_drd" : "rnd_crd", 64'(gd ? dbg_rdata : cpu_rdata), 64'(e_rd));
            end
            if (g && w && !f) shadow[int'(off / 4)] = wd;
            if (g) begin m_idx = e_idx; m_wd = wd; m_last_dbg = gd; end
            if (gd) m_run++;
            case (m_owner)
                0: begin
                    if (cpu_req && dbg_req) nxt = m_last_dbg ? 1 : 2;
                    else if (cpu_req) nxt = 1;
                    else if (dbg_req) nxt = 2;
                    else nxt = 0;
                end
                1: nxt = 0;
                default: begin
                    starve = STARVE && cpu_req && (m_run >= MAXRUN);
                    nxt = (dbg_lock && dbg_req && !starve) ? 2 : 0;
                end
            endcase
            if (nxt != 2) m_run = 0;
            m_owner = nxt;
            p_cpu = gc; p_dbg = gd;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between the processor load/store path and a debug/loader port.
- Translates byte addresses into memory word indices and flags out-of-range or misaligned accesses.
- Drives a stall back to the processor while its request is pending, so the processor can hold PC and register writes.
- Sits between the processor datapath (ALU result, ReadData2, MemRead/MemWrite) and the DataMemory instance.

Parameters:
BASE_ADDR, 32'h1001_0000, byte address mapped to memory word 0
MEMORY_DEPTH, 1024, number of 32-bit words in the data memory
ADDR_W, 10, width of word index output; must satisfy 2**ADDR_W >= MEMORY_DEPTH
MAX_DBG_RUN, 8, maximum consecutive locked debug accesses (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  processor access request (MemRead | MemWrite)
cpu_we  in  1  processor write enable (1 = store, 0 = load)
cpu_addr  in  32  processor byte address (ALU result)
cpu_wdata  in  32  processor store data
cpu_rdata  out  32  load data to processor
cpu_ack  out  1  one-cycle pulse: processor access completed
cpu_stall  out  1  processor must hold state
dbg_req  in  1  debug/loader request
dbg_we  in  1  debug write enable
dbg_lock  in  1  debug burst lock (keep grant while asserted)
dbg_addr  in  32  debug byte address
dbg_wdata  in  32  debug write data
dbg_rdata  out  32  read data to debug port
dbg_ack  out  1  one-cycle pulse: debug access completed
mem_addr  out  ADDR_W  word index to DataMemory
mem_wdata  out  32  write data to DataMemory
mem_we  out  1  DataMemory write enable
mem_re  out  1  DataMemory read enable
mem_rdata  in  32  DataMemory read data (combinational read)
addr_fault  out  1  one-cycle pulse: acknowledged access was out of range or misaligned

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- FSM states: IDLE, GNT_CPU, GNT_DBG. Reset state is IDLE; last_winner resets to DBG, so the CPU wins the first tie.
- Reset values: all acks, mem_we, mem_re and addr_fault are 0; mem_addr, mem_wdata, cpu_rdata and dbg_rdata are 0.
- cpu_stall = cpu_req & ~cpu_ack, combinational; it is 0 during reset.
- IDLE transitions:
  - Only cpu_req -> GNT_CPU.
  - Only dbg_req -> GNT_DBG.
  - Both -> grant the requester that is not last_winner (round-robin).
  - Neither -> stay in IDLE.
- Grant states:
  - Memory outputs are driven from the granted requester.
  - The access completes in that cycle: the matching ack = 1 and rdata = mem_rdata.
  - last_winner is updated.
- Exit from GNT_CPU: always to IDLE.
- Exit from GNT_DBG: stay in GNT_DBG if dbg_lock & dbg_req; otherwise go to IDLE.
- Latency and throughput:
  - Uncontended access: request sampled at edge N, ack in cycle N+1.
  - Back-to-back accesses from the same unlocked requester: one per 2 cycles.
  - A locked debug burst: one access per cycle.
- Address translation: offset = addr - BASE_ADDR (32-bit wrap); mem_addr = offset[ADDR_W+1:2].
- Faults:
  - Condition: offset[1:0] != 0, or offset >= 4*MEMORY_DEPTH (including underflow wrap).
  - On fault: mem_we = 0, mem_re = 0, ack still pulses, rdata = 0, addr_fault = 1 for that cycle.
- mem_re = granted & ~we & ~fault; mem_we = granted & we & ~fault.
- Outside grant states: mem_we and mem_re are 0; mem_addr and mem_wdata hold their last value.
- A request dropped while in IDLE is simply not granted.
- A requester must hold req, we, addr and wdata stable until its ack.
- A request dropped while granted still completes; the ack is ignored by the requester.
- Reset asserted mid-grant: the access in that cycle is suppressed (no we, no ack); the FSM returns to IDLE next edge.

Optional Feature:
- Macro: DMEM_ARB_STARVE_LIMIT_EN.
- Defined:
  - A 4-bit-or-wider run counter counts consecutive GNT_DBG cycles and resets to 0 on leaving GNT_DBG.
  - When the counter reaches MAX_DBG_RUN and cpu_req = 1, the FSM leaves GNT_DBG for IDLE regardless of dbg_lock.
  - The CPU then wins the next arbitration (last_winner = DBG).
- Not defined: dbg_lock holds the grant indefinitely; the CPU may starve.

Test Plan:
1. After reset, cpu_req=1, cpu_we=1, cpu_addr=32'h1001_0008, wdata=32'hDEAD_BEEF -> next cycle mem_we=1, mem_addr=2, cpu_ack=1, cpu_stall 1 then 0; a following load from the same address returns 32'hDEAD_BEEF.
2. cpu_req and dbg_req both held high, no lock -> grants alternate CPU, DBG, CPU, ..., each separated by one IDLE cycle; CPU wins first.
3. dbg_lock=1, dbg_req=1 for 12 reads, cpu_req=1 throughout, macro undefined -> 12 consecutive dbg_ack, cpu_ack only after the lock drops.
4. Same as 3 with DMEM_ARB_STARVE_LIMIT_EN and MAX_DBG_RUN=8 -> exactly 8 dbg_ack, then IDLE, then cpu_ack, then debug resumes.
5. cpu_addr=32'h1000_FFFC (below base), then 32'h1001_0002 (misaligned), then BASE+4096 -> each gives cpu_ack=1, addr_fault=1, mem_we=mem_re=0, cpu_rdata=0.
6. reset asserted in the GNT_DBG cycle of a write -> no mem_we, no dbg_ack; state is IDLE; with cpu_req and dbg_req both high after reset, the CPU wins.
